// File: rtl/csr_commit_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// csr_commit_ctrl_pkg
//   Shared definitions for the write-back CSR commit controller: CSR
//   operation codes, the interrupt exception code, redirect FSM state
//   encodings and a helper that sizes the drain counter.
// ---------------------------------------------------------------------------
package csr_commit_ctrl_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RD   = 2'b01,
    CSR_OP_WR   = 2'b10,
    CSR_OP_XCHG = 2'b11
  } csr_op_e;

  localparam logic [5:0] ECODE_INT     = 6'h00;
  localparam logic [8:0] ESUBCODE_NONE = 9'h000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_e;

  // Width of a counter holding 0..n; never narrower than one bit so a
  // zero-length drain still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/csr_commit_ctrl_if.sv
// ---------------------------------------------------------------------------
// csr_commit_ctrl_if
//   Bundles the three handshakes of the commit controller:
//     ws_*      : instruction arriving from the write-back stage
//     csr_*     : request/response to the CSR register file
//     redir_*   : registered fetch redirect request
//   master : the commit controller
//   slave  : the surrounding pipeline / CSR file / fetch unit
// ---------------------------------------------------------------------------
interface csr_commit_ctrl_if;

  logic        ws_valid;
  logic        ws_ready;
  logic [31:0] ws_pc;
  logic        ws_ex;
  logic [5:0]  ws_ecode;
  logic [8:0]  ws_esubcode;
  logic [31:0] ws_vaddr;
  logic        ws_ertn;
  logic [1:0]  ws_csr_op;
  logic [13:0] ws_csr_num;
  logic [31:0] ws_rj_value;
  logic [31:0] ws_rkd_value;

  logic [13:0] csr_num;
  logic        csr_re;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;

  logic        redir_valid;
  logic [31:0] redir_target;
  logic        redir_ready;

  modport master (
    input  ws_valid, ws_pc, ws_ex, ws_ecode, ws_esubcode, ws_vaddr, ws_ertn,
           ws_csr_op, ws_csr_num, ws_rj_value, ws_rkd_value,
           csr_rvalue, redir_ready,
    output ws_ready, csr_num, csr_re, csr_we, csr_wmask, csr_wvalue,
           redir_valid, redir_target
  );

  modport slave (
    output ws_valid, ws_pc, ws_ex, ws_ecode, ws_esubcode, ws_vaddr, ws_ertn,
           ws_csr_op, ws_csr_num, ws_rj_value, ws_rkd_value,
           csr_rvalue, redir_ready,
    input  ws_ready, csr_num, csr_re, csr_we, csr_wmask, csr_wvalue,
           redir_valid, redir_target
  );

endinterface

// File: rtl/csr_commit_ctrl_ex_redirect_fsm.sv
// ---------------------------------------------------------------------------
// csr_commit_ctrl_ex_redirect_fsm
//   RUN -> REDIRECT on a committed exception/ERTN, REDIRECT -> DRAIN on the
//   fetch handshake, DRAIN -> RUN after DRAIN_CYCLES cycles.
// Ports
//   clk, resetn     : clock, synchronous active-low reset
//   ev              : exception or ERTN committed this cycle (only in RUN)
//   ev_is_ex        : the event is an exception (else ERTN)
//   ex_entry        : exception entry PC, sampled on ev
//   ertn_pc         : ERTN return PC, sampled on ev
//   redir_ready     : fetch accepts the redirect
//   state           : current FSM state
//   redir_valid     : registered redirect request
//   redir_target    : registered redirect PC
// ---------------------------------------------------------------------------
module csr_commit_ctrl_ex_redirect_fsm
  import csr_commit_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ev,
  input  logic        ev_is_ex,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_pc,
  input  logic        redir_ready,
  output state_e      state,
  output logic        redir_valid,
  output logic [31:0] redir_target
);

  localparam int              CNT_W      = cnt_width(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // NOTE: every combinational output gets a default before any branch so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RUN: begin
        if (ev) state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redir_valid && redir_ready) begin
          if (DRAIN_CYCLES == 0) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_DRAIN;
            cnt_nxt   = DRAIN_INIT;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt <= CNT_ONE) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_RUN;
      cnt          <= '0;
      redir_valid  <= 1'b0;
      redir_target <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      redir_valid <= (state_nxt == ST_REDIRECT);
      // Target is captured in the event cycle and held through REDIRECT.
      if (ev) redir_target <= ev_is_ex ? ex_entry : ertn_pc;
    end
  end

endmodule

// File: rtl/csr_commit_ctrl.sv
// ---------------------------------------------------------------------------
// csr_commit_ctrl
//   Write-back-stage initiator for the CSR register file. Converts the
//   committing instruction into CSR read/write requests, exception / ERTN
//   pulses and a GPR write of the old CSR value; converts pending
//   interrupts into INT exceptions; redirects fetch and drains wrong-path
//   instructions afterwards.
// Ports
//   clk, resetn          : clock, synchronous active-low reset
//   bus (master)         : ws_* instruction, csr_* register file, redir_*
//   has_int              : pending enabled interrupt
//   ertn_pc, ex_entry    : ERA / EENTRY from the CSR file
//   wb_ex, wb_pc, wb_ecode, wb_esubcode, wb_vaddr : exception commit
//   ertn_flush           : ERTN commit pulse
//   rf_we, rf_wdata      : GPR write of the pre-write CSR value
//   flush_all            : kill all earlier pipeline stages
// ---------------------------------------------------------------------------
module csr_commit_ctrl
  import csr_commit_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  csr_commit_ctrl_if.master   bus,
  input  logic                has_int,
  input  logic [31:0]         ertn_pc,
  input  logic [31:0]         ex_entry,
  output logic                wb_ex,
  output logic [31:0]         wb_pc,
  output logic [5:0]          wb_ecode,
  output logic [8:0]          wb_esubcode,
  output logic [31:0]         wb_vaddr,
  output logic                ertn_flush,
  output logic                rf_we,
  output logic [31:0]         rf_wdata,
  output logic                flush_all
);

  state_e      state;
  logic        go;
  logic        ev;
  csr_op_e     op;
  logic        redir_valid;
  logic [31:0] redir_target;

  always_comb begin
    go  = bus.ws_valid && (state == ST_RUN);
    op  = csr_op_e'(bus.ws_csr_op);

    wb_ex          = 1'b0;
    wb_pc          = '0;
    wb_ecode       = '0;
    wb_esubcode    = '0;
    wb_vaddr       = '0;
    ertn_flush     = 1'b0;
    rf_we          = 1'b0;
    rf_wdata       = '0;
    bus.csr_num    = '0;
    bus.csr_re     = 1'b0;
    bus.csr_we     = 1'b0;
    bus.csr_wmask  = '0;
    bus.csr_wvalue = '0;

    if (go) begin
      bus.csr_num = bus.ws_csr_num;
      // Interrupt wins over everything; the instruction is not executed.
      if (has_int) begin
        wb_ex       = 1'b1;
        wb_pc       = bus.ws_pc;
        wb_ecode    = ECODE_INT;
        wb_esubcode = ESUBCODE_NONE;
      end else if (bus.ws_ex) begin
        wb_ex       = 1'b1;
        wb_pc       = bus.ws_pc;
        wb_ecode    = bus.ws_ecode;
        wb_esubcode = bus.ws_esubcode;
        wb_vaddr    = bus.ws_vaddr;
      end else if (bus.ws_ertn) begin
        ertn_flush = 1'b1;
      end else if (op != CSR_OP_NONE) begin
        bus.csr_re = 1'b1;
        rf_we      = 1'b1;
        rf_wdata   = bus.csr_rvalue;
        case (op)
          CSR_OP_WR: begin
            bus.csr_we     = 1'b1;
            bus.csr_wmask  = 32'hffff_ffff;
            bus.csr_wvalue = bus.ws_rkd_value;
          end
          CSR_OP_XCHG: begin
            bus.csr_we     = 1'b1;
            bus.csr_wmask  = bus.ws_rj_value;
            bus.csr_wvalue = bus.ws_rkd_value;
          end
          default: ;
        endcase
      end
    end

    ev           = wb_ex || ertn_flush;
    flush_all    = ev || (state != ST_RUN);
    bus.ws_ready = (state == ST_RUN);
  end

  csr_commit_ctrl_ex_redirect_fsm #(
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) u_fsm (
    .clk          (clk),
    .resetn       (resetn),
    .ev           (ev),
    .ev_is_ex     (wb_ex),
    .ex_entry     (ex_entry),
    .ertn_pc      (ertn_pc),
    .redir_ready  (bus.redir_ready),
    .state        (state),
    .redir_valid  (redir_valid),
    .redir_target (redir_target)
  );

  assign bus.redir_valid  = redir_valid;
  assign bus.redir_target = redir_target;

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csr_commit_ctrl
//   Two instances share one stimulus: dut (DRAIN_CYCLES=2) and dut0
//   (DRAIN_CYCLES=0). Single-cycle commit behaviour comes from a vector
//   table; redirect/drain/reset sequences are written out by hand.
// ---------------------------------------------------------------------------
module tb_csr_commit_ctrl;
  import csr_commit_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        ws_valid, ws_ex, ws_ertn, redir_ready, has_int;
  logic [31:0] ws_pc, ws_vaddr, ws_rj_value, ws_rkd_value, csr_rvalue;
  logic [5:0]  ws_ecode;
  logic [8:0]  ws_esubcode;
  logic [1:0]  ws_csr_op;
  logic [13:0] ws_csr_num;
  logic [31:0] ertn_pc, ex_entry;

  csr_commit_ctrl_if bus ();
  csr_commit_ctrl_if bus0 ();

  assign bus.ws_valid     = ws_valid;     assign bus0.ws_valid     = ws_valid;
  assign bus.ws_pc        = ws_pc;        assign bus0.ws_pc        = ws_pc;
  assign bus.ws_ex        = ws_ex;        assign bus0.ws_ex        = ws_ex;
  assign bus.ws_ecode     = ws_ecode;     assign bus0.ws_ecode     = ws_ecode;
  assign bus.ws_esubcode  = ws_esubcode;  assign bus0.ws_esubcode  = ws_esubcode;
  assign bus.ws_vaddr     = ws_vaddr;     assign bus0.ws_vaddr     = ws_vaddr;
  assign bus.ws_ertn      = ws_ertn;      assign bus0.ws_ertn      = ws_ertn;
  assign bus.ws_csr_op    = ws_csr_op;    assign bus0.ws_csr_op    = ws_csr_op;
  assign bus.ws_csr_num   = ws_csr_num;   assign bus0.ws_csr_num   = ws_csr_num;
  assign bus.ws_rj_value  = ws_rj_value;  assign bus0.ws_rj_value  = ws_rj_value;
  assign bus.ws_rkd_value = ws_rkd_value; assign bus0.ws_rkd_value = ws_rkd_value;
  assign bus.csr_rvalue   = csr_rvalue;   assign bus0.csr_rvalue   = csr_rvalue;
  assign bus.redir_ready  = redir_ready;  assign bus0.redir_ready  = redir_ready;

  logic        wb_ex, ertn_flush, rf_we, flush_all;
  logic [31:0] wb_pc, wb_vaddr, rf_wdata;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        wb_ex0, ertn_flush0, rf_we0, flush_all0;
  logic [31:0] wb_pc0, wb_vaddr0, rf_wdata0;
  logic [5:0]  wb_ecode0;
  logic [8:0]  wb_esubcode0;

  csr_commit_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .has_int(has_int),
    .ertn_pc(ertn_pc), .ex_entry(ex_entry),
    .wb_ex(wb_ex), .wb_pc(wb_pc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .rf_we(rf_we),
    .rf_wdata(rf_wdata), .flush_all(flush_all)
  );

  csr_commit_ctrl #(.DRAIN_CYCLES(0)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0), .has_int(has_int),
    .ertn_pc(ertn_pc), .ex_entry(ex_entry),
    .wb_ex(wb_ex0), .wb_pc(wb_pc0), .wb_ecode(wb_ecode0), .wb_esubcode(wb_esubcode0),
    .wb_vaddr(wb_vaddr0), .ertn_flush(ertn_flush0), .rf_we(rf_we0),
    .rf_wdata(rf_wdata0), .flush_all(flush_all0)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        valid, has_int, ex, ertn;
    logic [1:0]  op;
    logic [13:0] num;
    logic [31:0] pc;
    logic [5:0]  ecode;
    logic [31:0] rj, rkd, rvalue;
    logic        e_wb_ex, e_ertn, e_re, e_we, e_rf_we, e_flush;
    logic [13:0] e_num;
    logic [31:0] e_wmask, e_wvalue, e_wdata, e_pc;
    logic [5:0]  e_ecode;
  } vec_t;

  vec_t        vecs[$];
  vec_t        exp_q[$];
  logic [31:0] tgt_q[$];

  task automatic idle_inputs();
    ws_valid = 0; ws_ex = 0; ws_ertn = 0; has_int = 0; redir_ready = 0;
    ws_pc = '0; ws_vaddr = '0; ws_rj_value = '0; ws_rkd_value = '0;
    csr_rvalue = '0; ws_ecode = '0; ws_esubcode = '0; ws_csr_op = '0;
    ws_csr_num = '0; ertn_pc = '0; ex_entry = '0;
  endtask

  task automatic drive(input vec_t v);
    ws_valid = v.valid; has_int = v.has_int; ws_ex = v.ex; ws_ertn = v.ertn;
    ws_csr_op = v.op; ws_csr_num = v.num; ws_pc = v.pc; ws_ecode = v.ecode;
    ws_esubcode = '0; ws_vaddr = '0;
    ws_rj_value = v.rj; ws_rkd_value = v.rkd; csr_rvalue = v.rvalue;
  endtask

  task automatic build_vectors();
    vec_t v;
    // csrwr SAVE0: old value to GPR, full mask
    v = '0; v.valid = 1; v.op = CSR_OP_WR; v.num = 14'h030; v.pc = 32'h1c000010;
    v.rkd = 32'h12345678; v.rj = 32'hdeadbeef; v.rvalue = 32'h000000a5;
    v.e_re = 1; v.e_we = 1; v.e_rf_we = 1; v.e_num = 14'h030;
    v.e_wmask = 32'hffffffff; v.e_wvalue = 32'h12345678; v.e_wdata = 32'h000000a5;
    vecs.push_back(v);
    // csrrd: read only
    v = '0; v.valid = 1; v.op = CSR_OP_RD; v.num = 14'h005; v.rvalue = 32'h00001234;
    v.rkd = 32'h55555555; v.e_re = 1; v.e_rf_we = 1; v.e_num = 14'h005; v.e_wdata = 32'h00001234;
    vecs.push_back(v);
    // csrxchg: mask from rj
    v = '0; v.valid = 1; v.op = CSR_OP_XCHG; v.num = 14'h000; v.rj = 32'h0000ff00;
    v.rkd = 32'habcd1234; v.rvalue = 32'h00000077;
    v.e_re = 1; v.e_we = 1; v.e_rf_we = 1; v.e_wmask = 32'h0000ff00;
    v.e_wvalue = 32'habcd1234; v.e_wdata = 32'h00000077;
    vecs.push_back(v);
    // interrupt on a csrxchg: INT exception, no CSR access
    v = '0; v.valid = 1; v.has_int = 1; v.op = CSR_OP_XCHG; v.num = 14'h006; v.pc = 32'h1c000040;
    v.rj = 32'hffffffff; v.rkd = 32'h1; v.rvalue = 32'h99;
    v.e_wb_ex = 1; v.e_flush = 1; v.e_num = 14'h006; v.e_pc = 32'h1c000040; v.e_ecode = 6'h00;
    vecs.push_back(v);
    // flagged exception on a csrwr
    v = '0; v.valid = 1; v.ex = 1; v.ecode = 6'h08; v.op = CSR_OP_WR; v.num = 14'h030;
    v.pc = 32'h1c000080; v.rkd = 32'h1; v.rvalue = 32'h2;
    v.e_wb_ex = 1; v.e_flush = 1; v.e_num = 14'h030; v.e_pc = 32'h1c000080; v.e_ecode = 6'h08;
    vecs.push_back(v);
    // ertn
    v = '0; v.valid = 1; v.ertn = 1; v.pc = 32'h1c0000c0; v.e_ertn = 1; v.e_flush = 1;
    vecs.push_back(v);
    // plain instruction, no CSR op
    v = '0; v.valid = 1; v.num = 14'h011; v.rvalue = 32'h3; v.e_num = 14'h011;
    vecs.push_back(v);
    // not valid: nothing happens even with csrwr and interrupt present
    v = '0; v.has_int = 1; v.op = CSR_OP_WR; v.num = 14'h030; v.rkd = 32'h7; v.rvalue = 32'h8;
    vecs.push_back(v);
  endtask

  logic [31:0] exp_tgt;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    resetn = 0;
    build_vectors();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ws_ready", bus.ws_ready, 1);
    check("rst.redir_valid", bus.redir_valid, 0);
    check("rst.redir_target", bus.redir_target, 0);
    check("rst.flush_all", flush_all, 0);
    check("rst.wb_ex", wb_ex, 0);
    check("rst.csr_re", bus.csr_re, 0);
    check("rst.rf_we", rf_we, 0);

    // ---------------- table-driven single-cycle commits ----------------
    foreach (vecs[i]) begin
      vec_t e;
      @(posedge clk); #1;
      resetn = 1;
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d.wb_ex", i), wb_ex, e.e_wb_ex);
      check($sformatf("v%0d.ertn_flush", i), ertn_flush, e.e_ertn);
      check($sformatf("v%0d.csr_re", i), bus.csr_re, e.e_re);
      check($sformatf("v%0d.csr_we", i), bus.csr_we, e.e_we);
      check($sformatf("v%0d.rf_we", i), rf_we, e.e_rf_we);
      check($sformatf("v%0d.flush_all", i), flush_all, e.e_flush);
      check($sformatf("v%0d.csr_num", i), bus.csr_num, e.e_num);
      check($sformatf("v%0d.csr_wmask", i), bus.csr_wmask, e.e_wmask);
      check($sformatf("v%0d.csr_wvalue", i), bus.csr_wvalue, e.e_wvalue);
      check($sformatf("v%0d.rf_wdata", i), rf_wdata, e.e_wdata);
      check($sformatf("v%0d.wb_pc", i), wb_pc, e.e_pc);
      check($sformatf("v%0d.wb_ecode", i), wb_ecode, e.e_ecode);
      ws_valid = 0;
      if (e.e_flush) resetn = 0;  // abort the redirect before it starts
    end
    @(posedge clk); #1;
    resetn = 1;
    idle_inputs();

    // ---------------- exception, held redirect, drain ----------------
    ws_valid = 1; ws_ex = 1; ws_pc = 32'h1c000100; ws_ecode = 6'h08;
    ws_esubcode = 9'h000; ws_vaddr = 32'h1c000100; ex_entry = 32'h1c008000;
    tgt_q.push_back(32'h1c008000);
    @(negedge clk);
    check("ex.wb_ex", wb_ex, 1);
    check("ex.flush_all", flush_all, 1);
    check("ex.wb_pc", wb_pc, 32'h1c000100);
    check("ex.wb_ecode", wb_ecode, 6'h08);
    check("ex.wb_vaddr", wb_vaddr, 32'h1c000100);
    @(posedge clk); #1;
    ws_valid = 0; ws_ex = 0; ex_entry = 32'h0bad0000;
    exp_tgt = tgt_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("ex.hold%0d.redir_valid", k), bus.redir_valid, 1);
      check($sformatf("ex.hold%0d.redir_target", k), bus.redir_target, exp_tgt);
      check($sformatf("ex.hold%0d.ws_ready", k), bus.ws_ready, 0);
      check($sformatf("ex.hold%0d.flush_all", k), flush_all, 1);
      @(posedge clk); #1;
    end
    redir_ready = 1;
    @(negedge clk);
    check("ex.hs.redir_valid", bus.redir_valid, 1);
    @(posedge clk); #1;
    redir_ready = 0;
    // wrong-path instruction plus interrupt during drain must be ignored
    ws_valid = 1; ws_csr_op = CSR_OP_WR; ws_rkd_value = 32'h1; has_int = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("drain%0d.ws_ready", k), bus.ws_ready, 0);
      check($sformatf("drain%0d.flush_all", k), flush_all, 1);
      check($sformatf("drain%0d.redir_valid", k), bus.redir_valid, 0);
      check($sformatf("drain%0d.wb_ex", k), wb_ex, 0);
      check($sformatf("drain%0d.csr_we", k), bus.csr_we, 0);
      check($sformatf("drain%0d.rf_we", k), rf_we, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("run.ws_ready", bus.ws_ready, 1);
    check("run.int.wb_ex", wb_ex, 1);
    check("run.int.wb_ecode", wb_ecode, 6'h00);
    check("run.int.csr_we", bus.csr_we, 0);
    idle_inputs();
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;

    // ---------------- ertn redirect ----------------
    ws_valid = 1; ws_ertn = 1; ertn_pc = 32'h1c000200; ex_entry = 32'h1c008000;
    tgt_q.push_back(32'h1c000200);
    @(negedge clk);
    check("ertn.ertn_flush", ertn_flush, 1);
    check("ertn.wb_ex", wb_ex, 0);
    check("ertn.flush_all", flush_all, 1);
    @(posedge clk); #1;
    ws_valid = 0; ws_ertn = 0; ertn_pc = 32'h0;
    @(negedge clk);
    exp_tgt = tgt_q.pop_front();
    check("ertn.redir_valid", bus.redir_valid, 1);
    check("ertn.redir_target", bus.redir_target, exp_tgt);
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;

    // ---------------- ex and ertn together; zero-length drain ----------------
    ws_valid = 1; ws_ex = 1; ws_ertn = 1; ws_ecode = 6'h08;
    ex_entry = 32'h1c008000; ertn_pc = 32'h1c000200;
    tgt_q.push_back(32'h1c008000);
    @(negedge clk);
    check("both.wb_ex", wb_ex, 1);
    check("both.ertn_flush", ertn_flush, 0);
    check("both.dut0.wb_ex", wb_ex0, 1);
    @(posedge clk); #1;
    ws_valid = 0; ws_ex = 0; ws_ertn = 0; ex_entry = 32'h0; redir_ready = 1;
    @(negedge clk);
    exp_tgt = tgt_q.pop_front();
    check("both.redir_target", bus.redir_target, exp_tgt);
    check("both.dut0.redir_valid", bus0.redir_valid, 1);
    check("both.dut0.redir_target", bus0.redir_target, exp_tgt);
    @(posedge clk); #1;
    redir_ready = 0;
    @(negedge clk);
    check("drain0.dut0.ws_ready", bus0.ws_ready, 1);
    check("drain0.dut0.flush_all", flush_all0, 0);
    check("drain0.dut0.redir_valid", bus0.redir_valid, 0);
    check("drain2.dut.ws_ready", bus.ws_ready, 0);
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;

    // ---------------- reset during REDIRECT ----------------
    ws_valid = 1; ws_ex = 1; ws_ecode = 6'h08; ex_entry = 32'h1c008000;
    @(posedge clk); #1;
    ws_valid = 0; ws_ex = 0;
    @(negedge clk);
    check("rstmid.pre.redir_valid", bus.redir_valid, 1);
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
    @(negedge clk);
    check("rstmid.redir_valid", bus.redir_valid, 0);
    check("rstmid.flush_all", flush_all, 0);
    check("rstmid.ws_ready", bus.ws_ready, 1);

    check("sb.tgt_q_empty", tgt_q.size(), 0);
    check("sb.exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
